led_event_scheduler: RTL

- Shares the board's 8-LED bank between N_EVT button-triggered light-effect generators; each generator is a shift-chain ripple of the same kind as the existing event modules.
- Captures button presses as pending requests and grants them round-robin, one effect at a time.
- Sequences the granted generator with a start pulse and a divided step tick, muxes its LED pattern to the pins, then inserts a blank gap before the next grant.

---
 rtl/led_event_scheduler_pkg.sv | 28 ++
 rtl/led_event_scheduler_rr_arbiter.sv | 43 ++++
 rtl/led_event_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/led_event_scheduler_pkg.sv
// rtl/led_event_scheduler_pkg.sv - shared state codes and width helpers for the LED event scheduler
//
// Holds the FSM state constants and small constant functions used to size
// the grant index and the step/divider counters.

package led_event_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Width of an index that selects one of n requesters (never below 1 bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that runs 0..n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_event_scheduler_rr_arbiter.sv
// rtl/led_event_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req         in   N_EVT  pending request vector
//   last        in   IDW    index granted most recently
//   grant_idx   out  IDW    first requester found searching upward from last+1
//   grant_valid out  1      at least one request is pending

module rr_arbiter #(
    parameter int N_EVT = 4,
    parameter int IDW   = 2
) (
    input  logic [N_EVT-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_valid
);

    // One spare bit so last+k (at most 2*N_EVT-1) can be compared before wrapping.
    localparam int JW = IDW + 1;
    localparam logic [JW-1:0] N_W = JW'(N_EVT);

    logic [JW-1:0] j;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = '0;
        // k = N_EVT comes back around to last itself, so a lone requester
        // that was just served can still be granted again.
        for (int k = 1; k <= N_EVT; k++) begin
            j = {1'b0, last} + JW'(k);
            if (j >= N_W) begin
                j = j - N_W;
            end
            if (!grant_valid && req[j[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// rtl/led_event_scheduler.sv - round-robin sharing of one 8-LED bank between button-triggered effect generators
//
// Ports:
//   clk        in   1        system clock
//   rst        in   1        synchronous active-high reset
//   btn        in   N_EVT    synchronised button levels, one per requester
//   abort      in   1        cut the current run short
//   evt_led    in   8*N_EVT  generator LED patterns, slice i = [8i+7:8i]
//   evt_start  out  N_EVT    one-hot start/clear pulse to the granted generator
//   evt_step   out  1        step enable to the active generator
//   led        out  8        LED pins
//   busy       out  1        high while running an effect or in the blank gap
//   active_id  out  IDW      index of the current/last grant

module led_event_scheduler
    import led_event_scheduler_pkg::*;
#(
    parameter int N_EVT     = 4,
    parameter int TICK_DIV  = 4,
    parameter int RUN_STEPS = 9,
    parameter int GAP_STEPS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_EVT-1:0]            btn,
    input  logic                        abort,
    input  logic [8*N_EVT-1:0]          evt_led,
    output logic [N_EVT-1:0]            evt_start,
    output logic                        evt_step,
    output logic [7:0]                  led,
    output logic                        busy,
    output logic [id_width(N_EVT)-1:0]  active_id
);

    localparam int IDW   = id_width(N_EVT);
    localparam int DIVW  = cnt_width(TICK_DIV);
    localparam int STEPW = cnt_width(max2(RUN_STEPS, GAP_STEPS));

    localparam logic [DIVW-1:0]  DIV_LAST  = DIVW'(TICK_DIV - 1);
    localparam logic [STEPW-1:0] RUN_LAST  = STEPW'(RUN_STEPS - 1);
    localparam logic [STEPW-1:0] GAP_LAST  = STEPW'(GAP_STEPS - 1);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(N_EVT - 1);

    state_t             state;
    logic [N_EVT-1:0]   pending;
    logic [N_EVT-1:0]   btn_q;
    logic [IDW-1:0]     last_grant;
    logic [DIVW-1:0]    div_cnt;
    logic [STEPW-1:0]   step_cnt;
    logic               first_run;

    logic [N_EVT-1:0]   rise;
    logic [N_EVT-1:0]   grant_mask;
    logic [IDW-1:0]     grant_idx;
    logic               grant_valid;
    logic               tick;
    logic               run_done;
    logic               gap_done;
    logic               do_grant;

    assign rise = btn & ~btn_q;
    assign tick = (div_cnt == DIV_LAST);

    // abort ends the run on the next edge regardless of where the divider is.
    assign run_done = (state == ST_RUN) && (abort || (tick && (step_cnt == RUN_LAST)));
    assign gap_done = (state == ST_GAP) && tick && (step_cnt == GAP_LAST);

    // Arbitration only matters while idle or on the final gap cycle, which
    // lets back-to-back requests skip the idle cycle entirely.
    assign do_grant = grant_valid && ((state == ST_IDLE) || gap_done);

    rr_arbiter #(
        .N_EVT (N_EVT),
        .IDW   (IDW)
    ) u_arb (
        .req         (pending),
        .last        (last_grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_mask = '0;
        if (do_grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            btn_q      <= '0;
            last_grant <= LAST_INIT;
            active_id  <= '0;
            div_cnt    <= '0;
            step_cnt   <= '0;
            first_run  <= 1'b0;
        end else begin
            btn_q <= btn;
            // A fresh press on the index being granted survives the clear.
            pending   <= (pending & ~grant_mask) | rise;
            first_run <= do_grant;
            if (do_grant) begin
                active_id  <= grant_idx;
                last_grant <= grant_idx;
            end

            case (state)
                ST_IDLE: begin
                    if (do_grant) begin
                        state    <= ST_RUN;
                        div_cnt  <= '0;
                        step_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_done) begin
                        state    <= ST_GAP;
                        div_cnt  <= '0;
                        step_cnt <= '0;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                        if (tick) begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state    <= do_grant ? ST_RUN : ST_IDLE;
                        div_cnt  <= '0;
                        step_cnt <= '0;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                        if (tick) begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    div_cnt  <= '0;
                    step_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        evt_start = '0;
        if ((state == ST_RUN) && first_run) begin
            evt_start[active_id] = 1'b1;
        end
    end

    assign evt_step = (state == ST_RUN) && tick;
    assign busy     = (state != ST_IDLE);
    assign led      = (state == ST_RUN) ? evt_led[{active_id, 3'b000} +: 8] : 8'h00;

endmodule
